axi_write_arbiter: RTL and testbench

Two-requester arbiter that shares the single AXI4-Lite write slave (2-bit address, 32-bit data, register-file write port) between master 0 and master 1. It sits between the two bus masters and the write slave, grants one master at a time, and forwards its AW, W and B channels. The grant holds from the first AW/W handshake until the B handshake completes, so every write transaction is atomic.

---
 rtl/axi_write_arbiter.sv | 159 +++++++++++++++
 tb/tb_axi_write_arbiter.sv | 228 ++++++++++++++++++++++
 2 files changed

// File: rtl/axi_write_arbiter.sv
// Two-master AXI4-Lite write arbiter; grant held from first AW/W until the B handshake.
// Define AXI_WRITE_ARB_RR_EN for round-robin ties, otherwise master 0 has fixed priority.
`timescale 1ns/1ps
module axi_write_arbiter (
  input  logic        ACLK,
  input  logic        ARESETN,
  input  logic [1:0]  M0_AWADDR,
  input  logic        M0_AWVALID,
  output logic        M0_AWREADY,
  input  logic [31:0] M0_WDATA,
  input  logic        M0_WVALID,
  output logic        M0_WREADY,
  output logic [1:0]  M0_BRESP,
  output logic        M0_BVALID,
  input  logic        M0_BREADY,
  input  logic [1:0]  M1_AWADDR,
  input  logic        M1_AWVALID,
  output logic        M1_AWREADY,
  input  logic [31:0] M1_WDATA,
  input  logic        M1_WVALID,
  output logic        M1_WREADY,
  output logic [1:0]  M1_BRESP,
  output logic        M1_BVALID,
  input  logic        M1_BREADY,
  output logic [1:0]  S_AWADDR,
  output logic        S_AWVALID,
  input  logic        S_AWREADY,
  output logic [31:0] S_WDATA,
  output logic        S_WVALID,
  input  logic        S_WREADY,
  input  logic [1:0]  S_BRESP,
  input  logic        S_BVALID,
  output logic        S_BREADY,
  output logic [1:0]  GRANT,
  output logic        BUSY
);
  localparam int NUM_M = 2;

  typedef enum logic [1:0] {IDLE, XFER, RESP} state_t;
  state_t state, state_nxt;

  logic [NUM_M-1:0]       grant, grant_nxt, pick, req;
  logic                   aw_done, aw_done_nxt, w_done, w_done_nxt;
  logic                   aw_hs, w_hs, b_hs, xfer, resp;

  logic [NUM_M-1:0][1:0]  m_awaddr, m_bresp;
  logic [NUM_M-1:0][31:0] m_wdata;
  logic [NUM_M-1:0]       m_awvalid, m_wvalid, m_bready;
  logic [NUM_M-1:0]       m_awready, m_wready, m_bvalid;
  logic                   sel_awvalid, sel_wvalid, sel_bready;

  assign m_awaddr  = {M1_AWADDR,  M0_AWADDR};
  assign m_wdata   = {M1_WDATA,   M0_WDATA};
  assign m_awvalid = {M1_AWVALID, M0_AWVALID};
  assign m_wvalid  = {M1_WVALID,  M0_WVALID};
  assign m_bready  = {M1_BREADY,  M0_BREADY};

  assign {M1_AWREADY, M0_AWREADY} = m_awready;
  assign {M1_WREADY,  M0_WREADY}  = m_wready;
  assign {M1_BVALID,  M0_BVALID}  = m_bvalid;
  assign {M1_BRESP,   M0_BRESP}   = m_bresp;

  assign xfer = (state == XFER);
  assign resp = (state == RESP);
  assign req  = m_awvalid | m_wvalid;

  // grant is zero in IDLE, so the slave-side mux outputs zero there
  always_comb begin
    S_AWADDR    = '0;
    S_WDATA     = '0;
    sel_awvalid = 1'b0;
    sel_wvalid  = 1'b0;
    sel_bready  = 1'b0;
    for (int i = 0; i < NUM_M; i++) begin
      if (grant[i]) begin
        S_AWADDR    = m_awaddr[i];
        S_WDATA     = m_wdata[i];
        sel_awvalid = m_awvalid[i];
        sel_wvalid  = m_wvalid[i];
        sel_bready  = m_bready[i];
      end
    end
  end

  assign S_AWVALID = xfer & sel_awvalid & ~aw_done;
  assign S_WVALID  = xfer & sel_wvalid  & ~w_done;
  assign S_BREADY  = resp & sel_bready;

  assign aw_hs = S_AWVALID & S_AWREADY;
  assign w_hs  = S_WVALID  & S_WREADY;
  assign b_hs  = S_BVALID  & S_BREADY;

  for (genvar g = 0; g < NUM_M; g++) begin : g_mport
    assign m_awready[g] = grant[g] & xfer & S_AWREADY & ~aw_done;
    assign m_wready[g]  = grant[g] & xfer & S_WREADY  & ~w_done;
    assign m_bvalid[g]  = grant[g] & resp & S_BVALID;
    assign m_bresp[g]   = grant[g] ? S_BRESP : 2'b00;
  end

`ifdef AXI_WRITE_ARB_RR_EN
  logic ptr;

  assign pick = (req == 2'b11) ? (ptr ? 2'b10 : 2'b01) : req;

  always_ff @(posedge ACLK or negedge ARESETN) begin
    if (!ARESETN)  ptr <= 1'b0;
    else if (b_hs) ptr <= ~ptr;
  end
`else
  assign pick = req[0] ? 2'b01 : {req[1], 1'b0};
`endif

  always_comb begin
    state_nxt   = state;
    grant_nxt   = grant;
    aw_done_nxt = aw_done;
    w_done_nxt  = w_done;
    case (state)
      IDLE: if (|req) begin
        grant_nxt = pick;
        state_nxt = XFER;
      end
      XFER: begin
        aw_done_nxt = aw_done | aw_hs;
        w_done_nxt  = w_done  | w_hs;
        if (aw_done_nxt && w_done_nxt) state_nxt = RESP;
      end
      RESP: if (b_hs) begin
        state_nxt   = IDLE;
        grant_nxt   = '0;
        aw_done_nxt = 1'b0;
        w_done_nxt  = 1'b0;
      end
      default: begin
        state_nxt   = IDLE;
        grant_nxt   = '0;
        aw_done_nxt = 1'b0;
        w_done_nxt  = 1'b0;
      end
    endcase
  end

  always_ff @(posedge ACLK or negedge ARESETN) begin
    if (!ARESETN) begin
      state   <= IDLE;
      grant   <= '0;
      aw_done <= 1'b0;
      w_done  <= 1'b0;
    end else begin
      state   <= state_nxt;
      grant   <= grant_nxt;
      aw_done <= aw_done_nxt;
      w_done  <= w_done_nxt;
    end
  end

  assign GRANT = grant;
  assign BUSY  = (state != IDLE);
endmodule

// File: tb/tb_axi_write_arbiter.sv
// Directed bench for axi_write_arbiter: zero-wait slave model, per-master scoreboards, grant log.
`timescale 1ns/1ps
module tb_axi_write_arbiter;
  logic        ACLK, ARESETN;
  logic [1:0]  M0_AWADDR, M1_AWADDR, M0_BRESP, M1_BRESP, S_AWADDR, S_BRESP, GRANT;
  logic        M0_AWVALID, M0_AWREADY, M0_WVALID, M0_WREADY, M0_BVALID, M0_BREADY;
  logic        M1_AWVALID, M1_AWREADY, M1_WVALID, M1_WREADY, M1_BVALID, M1_BREADY;
  logic [31:0] M0_WDATA, M1_WDATA, S_WDATA;
  logic        S_AWVALID, S_AWREADY, S_WVALID, S_WREADY, S_BVALID, S_BREADY, BUSY;

  axi_write_arbiter dut (
    .ACLK(ACLK), .ARESETN(ARESETN),
    .M0_AWADDR(M0_AWADDR), .M0_AWVALID(M0_AWVALID), .M0_AWREADY(M0_AWREADY),
    .M0_WDATA(M0_WDATA), .M0_WVALID(M0_WVALID), .M0_WREADY(M0_WREADY),
    .M0_BRESP(M0_BRESP), .M0_BVALID(M0_BVALID), .M0_BREADY(M0_BREADY),
    .M1_AWADDR(M1_AWADDR), .M1_AWVALID(M1_AWVALID), .M1_AWREADY(M1_AWREADY),
    .M1_WDATA(M1_WDATA), .M1_WVALID(M1_WVALID), .M1_WREADY(M1_WREADY),
    .M1_BRESP(M1_BRESP), .M1_BVALID(M1_BVALID), .M1_BREADY(M1_BREADY),
    .S_AWADDR(S_AWADDR), .S_AWVALID(S_AWVALID), .S_AWREADY(S_AWREADY),
    .S_WDATA(S_WDATA), .S_WVALID(S_WVALID), .S_WREADY(S_WREADY),
    .S_BRESP(S_BRESP), .S_BVALID(S_BVALID), .S_BREADY(S_BREADY),
    .GRANT(GRANT), .BUSY(BUSY)
  );

  typedef struct { int cyc; logic [1:0] g; } gev_t;

  int tests = 0, fails = 0, cyc = 0;
  logic [33:0] exp0_q[$], exp1_q[$];
  logic [34:0] got_q[$];
  gev_t        grant_q[$];
  logic [1:0]  g_prev = 2'b00;
  logic [1:0]  tie_exp [4];

  initial ACLK = 1'b0;
  always #5 ACLK = ~ACLK;
  always @(posedge ACLK) cyc++;

  initial begin
    #400000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  always @(negedge ACLK) if (GRANT !== g_prev) begin
    grant_q.push_back('{cyc, GRANT});
    g_prev = GRANT;
  end

  // slave: captures AW and W, raises BVALID one cycle after both have arrived
  logic        s_gaw, s_gw, s_m;
  logic [1:0]  s_addr;
  logic [31:0] s_data;
  always @(posedge ACLK or negedge ARESETN) begin
    if (!ARESETN) begin
      s_gaw <= 1'b0; s_gw <= 1'b0; S_BVALID <= 1'b0;
    end else begin
      if (S_AWVALID && S_AWREADY) begin s_gaw <= 1'b1; s_addr <= S_AWADDR; s_m <= GRANT[1]; end
      if (S_WVALID && S_WREADY) begin s_gw <= 1'b1; s_data <= S_WDATA; end
      if (s_gaw && s_gw && !S_BVALID) begin
        S_BVALID <= 1'b1; s_gaw <= 1'b0; s_gw <= 1'b0;
        got_q.push_back({s_m, s_addr, s_data});
      end else if (S_BVALID && S_BREADY) S_BVALID <= 1'b0;
    end
  end

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    tests++;
    assert (obs === exp) else begin
      fails++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic step;
    @(posedge ACLK); #1;
  endtask

  task automatic set_aw(input int m, input logic v);
    if (m == 0) M0_AWVALID = v; else M1_AWVALID = v;
  endtask
  task automatic set_w(input int m, input logic v);
    if (m == 0) M0_WVALID = v; else M1_WVALID = v;
  endtask
  task automatic set_b(input int m, input logic v);
    if (m == 0) M0_BREADY = v; else M1_BREADY = v;
  endtask

  // one complete write from master m; W leads AW by wlead cycles, BREADY held low bdly BVALID cycles
  task automatic mwrite(input int m, input logic [1:0] a, input logic [31:0] d,
                        input int wlead, input int bdly);
    logic awd, wd, bd, awr, wr, bv, br, mine;
    logic [1:0] mg;
    logic [33:0] ex;
    logic [34:0] got;
    int n, bn;
    awd = 0; wd = 0; bd = 0; bn = 0;
    mg = (m == 0) ? 2'b01 : 2'b10;
    if (m == 0) begin exp0_q.push_back({a, d}); M0_AWADDR = a; M0_WDATA = d; end
    else        begin exp1_q.push_back({a, d}); M1_AWADDR = a; M1_WDATA = d; end
    set_w(m, 1'b1); set_aw(m, wlead == 0); set_b(m, bdly == 0);
    n = 0;
    while (!(awd && wd) && n < 200) begin
      #1;
      mine = (GRANT == mg);
      awr  = (m == 0) ? (M0_AWVALID & M0_AWREADY) : (M1_AWVALID & M1_AWREADY);
      wr   = (m == 0) ? (M0_WVALID & M0_WREADY) : (M1_WVALID & M1_WREADY);
      if (mine) chk("other_quiet", (m == 0) ? {M1_AWREADY, M1_WREADY, M1_BVALID, M1_BRESP}
                                            : {M0_AWREADY, M0_WREADY, M0_BVALID, M0_BRESP}, 0);
      if (awr) chk("s_awaddr", S_AWADDR, a);
      if (wr)  chk("s_wdata", S_WDATA, d);
      if (wd && !awd) chk("w_done_xfer", (m == 0) ? {BUSY, M0_AWREADY, M0_WREADY}
                                                  : {BUSY, M1_AWREADY, M1_WREADY}, 3'b110);
      step; n++;
      if (awr) begin awd = 1; set_aw(m, 1'b0); end
      if (wr)  begin wd = 1; set_w(m, 1'b0); end
      if (!awd && n >= wlead) set_aw(m, 1'b1);
    end
    chk("xfer_done", {awd, wd}, 2'b11);
    n = 0;
    while (!bd && n < 200) begin
      #1;
      bv = (m == 0) ? M0_BVALID : M1_BVALID;
      br = (m == 0) ? M0_BREADY : M1_BREADY;
      chk("other_quiet_b", (m == 0) ? {M1_AWREADY, M1_WREADY, M1_BVALID, M1_BRESP}
                                    : {M0_AWREADY, M0_WREADY, M0_BVALID, M0_BRESP}, 0);
      if (bv && !br) chk("b_backpressure", {S_BREADY, BUSY, GRANT}, {2'b01, mg});
      if (bv && br)  chk("bresp", (m == 0) ? M0_BRESP : M1_BRESP, S_BRESP);
      step; n++;
      if (bv && br) bd = 1;
      else if (bv) begin bn++; if (bn >= bdly) set_b(m, 1'b1); end
    end
    chk("b_done", bd, 1);
    set_b(m, 1'b0);
    chk("idle_after_b", {BUSY, GRANT}, 0);
    ex = (m == 0) ? exp0_q.pop_front() : exp1_q.pop_front();
    chk("wr_count", got_q.size(), 1);
    if (got_q.size() != 0) begin
      got = got_q.pop_front();
      chk("wr_data", got, {m[0], ex});
    end
  endtask

  initial begin
    int gi, n;
    logic hs;
`ifdef AXI_WRITE_ARB_RR_EN
    tie_exp[0] = 2'b01; tie_exp[1] = 2'b10; tie_exp[2] = 2'b01; tie_exp[3] = 2'b10;
`else
    tie_exp[0] = 2'b01; tie_exp[1] = 2'b01; tie_exp[2] = 2'b01; tie_exp[3] = 2'b01;
`endif
    ARESETN = 0; S_AWREADY = 1; S_WREADY = 1; S_BRESP = 2'b00;
    M0_AWADDR = 0; M0_WDATA = 0; M0_BREADY = 0; M1_AWADDR = 0; M1_WDATA = 0; M1_BREADY = 0;
    M0_AWVALID = 1; M0_WVALID = 1; M1_AWVALID = 1; M1_WVALID = 1;

    // reset held with both masters requesting
    repeat (3) @(posedge ACLK);
    #1;
    chk("rst_handshake", {M0_AWREADY, M0_WREADY, M0_BVALID, M1_AWREADY, M1_WREADY, M1_BVALID,
                          S_AWVALID, S_WVALID, S_BREADY}, 0);
    chk("rst_grant_busy", {GRANT, BUSY}, 0);
    ARESETN = 1;
    step;
    chk("grant_after_rst", GRANT, 2'b01);
    ARESETN = 0;
    #1;
    chk("async_rst", {GRANT, BUSY, S_AWVALID, S_WVALID}, 0);
    M0_AWVALID = 0; M0_WVALID = 0; M1_AWVALID = 0; M1_WVALID = 0;
    step; ARESETN = 1; step;

    // single write from M1
    S_BRESP = 2'b00;
    mwrite(1, 2'd2, 32'hDEADBEEF, 0, 0);
    step;

    // W three cycles ahead of AW, SLVERR response forwarded
    S_BRESP = 2'b10;
    mwrite(0, 2'd1, 32'h12345678, 3, 0);
    step;

    // continuous tie from a fresh pointer
    S_BRESP = 2'b00;
    ARESETN = 0; #1; step; ARESETN = 1; step;
    grant_q.delete();
    fork
      for (int i = 0; i < 4; i++) mwrite(0, i[1:0], 32'h00001000 + i, 0, 0);
      for (int j = 0; j < 4; j++) mwrite(1, 2'(3 - j), 32'h11110000 + j, 0, 0);
    join
    gi = 0;
    foreach (grant_q[k]) if (grant_q[k].g != 2'b00 && gi < 4) begin
      chk($sformatf("tie_grant%0d", gi), grant_q[k].g, tie_exp[gi]);
      gi++;
    end
    chk("tie_grant_cnt", gi, 4);
    step;

    // response backpressure while M1 waits
    grant_q.delete();
    fork
      mwrite(0, 2'd0, 32'hA5A50000, 0, 5);
      begin step; mwrite(1, 2'd3, 32'h5A5A0001, 0, 0); end
    join
    chk("bp_seq", {grant_q[0].g, grant_q[1].g, grant_q[2].g}, 6'b01_00_10);
    chk("bp_idle_gap", grant_q[2].cyc - grant_q[1].cyc, 1);
    step;

    // reset in XFER after only the AW handshake
    M0_AWADDR = 2'd3; M0_WDATA = 32'hBAD00001; M0_AWVALID = 1;
    n = 0; hs = 0;
    while (!hs && n < 20) begin
      #1; hs = M0_AWVALID & M0_AWREADY;
      step; n++;
    end
    chk("mid_aw_hs", hs, 1);
    M0_AWVALID = 0;
    #1;
    chk("mid_xfer", {BUSY, GRANT, M0_AWREADY, S_AWVALID}, 5'b10100);
    M0_WVALID = 1; ARESETN = 0;
    #1;
    chk("mid_rst_out", {GRANT, BUSY, S_AWVALID, S_WVALID, M0_AWREADY, M0_WREADY, M0_BVALID}, 0);
    M0_WVALID = 0;
    step; ARESETN = 1; step;
    chk("mid_rst_nowrite", got_q.size(), 0);
    mwrite(0, 2'd3, 32'hCAFEF00D, 0, 0);

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end
endmodule
